// File: rtl/led_pkg.sv
// Shared encodings, phase/direction types and pattern helpers for the LED sequencer.
package led_pkg;

    localparam int unsigned MODE_WALK     = 0;
    localparam int unsigned MODE_PINGPONG = 1;
    localparam int unsigned MODE_BINARY   = 2;

    localparam int unsigned PAT_W = 4;

    localparam logic [PAT_W-1:0] PAT_FIRST = 4'b0001;
    localparam logic [PAT_W-1:0] PAT_LAST  = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } phase_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // True when exactly one bit of the pattern is set.
    function automatic logic is_onehot(input logic [PAT_W-1:0] p);
        return (p != '0) && ((p & (p - PAT_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running divide-by-DIV counter; tick marks the last cycle of each hold period.
module led_prescaler #(
    parameter int unsigned DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned PC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);

    logic [PC_W-1:0] pc;

    // Count while enabled, wrap at DIV-1; held at zero while disabled or in reset.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            pc <= '0;
        end else if (pc == PC_LAST) begin
            pc <= '0;
        end else begin
            pc <= pc + PC_W'(1);
        end
    end

    assign tick = en && (pc == PC_LAST);

endmodule

// File: rtl/led_1_4.sv
// Four-LED pattern sequencer: walking one, ping-pong or binary count, each step held DIV cycles.
module led_1_4
    import led_pkg::*;
#(
    parameter int unsigned DIV  = 5,
    parameter int unsigned MODE = 0
) (
    input  logic clk,
    input  logic rst,
    output logic led_1,
    output logic led_2,
    output logic led_3,
    output logic led_4
);

    phase_t           phase;
    phase_t           phase_nxt;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] pat_nxt;
    dir_t             dir;
    dir_t             dir_nxt;
    logic [PAT_W-1:0] adv_pat;
    dir_t             adv_dir;
    logic             tick;

    led_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (phase == RUN),
        .tick (tick)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= IDLE;
            pat   <= '0;
            dir   <= DIR_UP;
        end else begin
            phase <= phase_nxt;
            pat   <= pat_nxt;
            dir   <= dir_nxt;
        end
    end

    // Next pattern/direction for one advance; non-one-hot patterns recover to PAT_FIRST.
    always_comb begin
        adv_pat = PAT_FIRST;
        adv_dir = DIR_UP;
        if (MODE == MODE_BINARY) begin
            adv_pat = pat + PAT_W'(1);
            adv_dir = dir;
        end else if (MODE == MODE_PINGPONG) begin
            if (is_onehot(pat)) begin
                if (pat == PAT_LAST) begin
                    adv_pat = PAT_LAST >> 1;
                end else if (pat == PAT_FIRST) begin
                    adv_pat = PAT_FIRST << 1;
                end else if (dir == DIR_UP) begin
                    adv_pat = pat << 1;
                end else begin
                    adv_pat = pat >> 1;
                end
                if (adv_pat == PAT_LAST) begin
                    adv_dir = DIR_DOWN;
                end else if (adv_pat == PAT_FIRST) begin
                    adv_dir = DIR_UP;
                end else begin
                    adv_dir = dir;
                end
            end
        end else begin
            if (is_onehot(pat)) begin
                adv_pat = {pat[PAT_W-2:0], pat[PAT_W-1]};
            end
        end
    end

    // Phase FSM: IDLE loads the first pattern, RUN advances on each prescaler tick.
    always_comb begin
        phase_nxt = phase;
        pat_nxt   = pat;
        dir_nxt   = dir;
        case (phase)
            IDLE: begin
                phase_nxt = RUN;
                pat_nxt   = PAT_FIRST;
                dir_nxt   = DIR_UP;
            end
            RUN: begin
                if (tick) begin
                    pat_nxt = adv_pat;
                    dir_nxt = adv_dir;
                end
            end
            default: begin
                phase_nxt = IDLE;
            end
        endcase
    end

    assign {led_4, led_3, led_2, led_1} = pat;

endmodule

// File: tb/tb_led_1_4.sv
// Directed bench for led_1_4 across walking-one, ping-pong and binary modes.
module tb_led_1_4;

    logic clk;
    logic rst;

    logic [3:0] w5, w1, w7, p1, b1;

    int checks   = 0;
    int failures = 0;

    logic [3:0] walk5_exp [9]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                   4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] walk4_exp [4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] pp_exp    [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    logic [3:0] bin_exp   [17] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                   4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};

    led_1_4 #(.DIV(5), .MODE(0)) u_w5 (
        .clk(clk), .rst(rst), .led_1(w5[0]), .led_2(w5[1]), .led_3(w5[2]), .led_4(w5[3]));
    led_1_4 #(.DIV(1), .MODE(0)) u_w1 (
        .clk(clk), .rst(rst), .led_1(w1[0]), .led_2(w1[1]), .led_3(w1[2]), .led_4(w1[3]));
    led_1_4 #(.DIV(7), .MODE(0)) u_w7 (
        .clk(clk), .rst(rst), .led_1(w7[0]), .led_2(w7[1]), .led_3(w7[2]), .led_4(w7[3]));
    led_1_4 #(.DIV(1), .MODE(1)) u_p1 (
        .clk(clk), .rst(rst), .led_1(p1[0]), .led_2(p1[1]), .led_3(p1[2]), .led_4(p1[3]));
    led_1_4 #(.DIV(1), .MODE(2)) u_b1 (
        .clk(clk), .rst(rst), .led_1(b1[0]), .led_2(b1[1]), .led_3(b1[2]), .led_4(b1[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev1, prev7;
        int         run1, run7;

        prev1 = '0;
        prev7 = '0;
        run1  = 0;
        run7  = 0;

        // Reset held 20 cycles: every LED dark.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("reset_dark c=%0d", i), {w5, w1, w7, p1, b1}, 20'h0);
        end

        // Release; k counts edges from the first edge with rst high.
        rst = 1'b1;
        for (int k = 0; k < 45; k++) begin
            step();
            check($sformatf("walk_div5 k=%0d", k), 20'(w5), 20'(walk5_exp[k / 5]));
            check($sformatf("walk_div1 k=%0d", k), 20'(w1), 20'(walk4_exp[k % 4]));
            if (k < 12) check($sformatf("pingpong k=%0d", k), 20'(p1), 20'(pp_exp[k]));
            if (k < 17) check($sformatf("binary k=%0d", k), 20'(b1), 20'(bin_exp[k]));
            check($sformatf("onehot_w5 k=%0d", k), 20'($countones(w5)), 20'd1);
            check($sformatf("onehot_w1 k=%0d", k), 20'($countones(w1)), 20'd1);
            check($sformatf("onehot_w7 k=%0d", k), 20'($countones(w7)), 20'd1);

            // Hold-length measurement for DIV=1 and DIV=7.
            if (k == 0) begin
                prev1 = w1;
                prev7 = w7;
                run1  = 1;
                run7  = 1;
            end else begin
                if (w1 == prev1) run1++;
                else begin
                    check($sformatf("hold_div1 k=%0d", k), 20'(run1), 20'd1);
                    prev1 = w1;
                    run1  = 1;
                end
                if (w7 == prev7) run7++;
                else begin
                    check($sformatf("hold_div7 k=%0d", k), 20'(run7), 20'd7);
                    prev7 = w7;
                    run7  = 1;
                end
            end
        end

        // Full reset between runs.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset2_dark c=%0d", i), {w5, w1, w7, p1, b1}, 20'h0);
        end

        // Run DIV=5 walk up to pat=0100 with pc=3 (edge 13 after release).
        rst = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            check($sformatf("midrun_pre k=%0d", k), 20'(w5), 20'(walk5_exp[k / 5]));
        end

        // One-cycle reset mid-hold.
        rst = 1'b0;
        step();
        check("midrun_reset", {w5, w1, w7, p1, b1}, 20'h0);

        // Restart: 0001 held a full 5 cycles, then 0010.
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("midrun_restart k=%0d", k), 20'(w5), 20'h1);
        end
        step();
        check("midrun_advance", 20'(w5), 20'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
